// File: rtl/axis_header_splitter.sv
// rtl/axis_header_splitter.sv - gathers leading packet beats into a wide header word, forwards the rest as payload
module axis_header_splitter #(
    parameter int TDATA_WIDTH  = 64,
    parameter int TUSER_WIDTH  = 128,
    parameter int HEADER_BEATS = 4,
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8,
    localparam int HDR_WIDTH   = HEADER_BEATS * TDATA_WIDTH,
    localparam int HKEEP_WIDTH = HEADER_BEATS * TKEEP_WIDTH,
    localparam int CNT_WIDTH   = $clog2(HEADER_BEATS + 1)
) (
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,
    input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic [TKEEP_WIDTH-1:0] axis_in_tkeep,
    input  logic [TUSER_WIDTH-1:0] axis_in_tuser,
    input  logic                   axis_in_tvalid,
    output logic                   axis_in_tready,
    input  logic                   axis_in_tlast,
    output logic [HDR_WIDTH-1:0]   header_tdata,
    output logic [HKEEP_WIDTH-1:0] header_tkeep,
    output logic [TUSER_WIDTH-1:0] header_tuser,
    output logic [CNT_WIDTH-1:0]   header_beats,
    output logic                   header_short,
    output logic                   header_tvalid,
    input  logic                   header_tready,
    output logic [TDATA_WIDTH-1:0] axis_payload_tdata,
    output logic [TKEEP_WIDTH-1:0] axis_payload_tkeep,
    output logic [TUSER_WIDTH-1:0] axis_payload_tuser,
    output logic                   axis_payload_tvalid,
    input  logic                   axis_payload_tready,
    output logic                   axis_payload_tlast
);

    typedef enum logic {ST_HDR, ST_PAY} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [HDR_WIDTH-1:0]   acc_data_q, acc_data_merged;
    logic [HKEEP_WIDTH-1:0] acc_keep_q, acc_keep_merged;
    logic [TUSER_WIDTH-1:0] pkt_user_q, first_user;
    logic                   is_complete, hdr_slot_free, pay_slot_free;
    logic                   hdr_accept, complete_accept, pay_accept;

    assign hdr_slot_free = !header_tvalid || header_tready;
    assign pay_slot_free = !axis_payload_tvalid || axis_payload_tready;

    always_comb begin
        state_d        = state_q;
        is_complete    = 1'b0;
        axis_in_tready = 1'b0;
        case (state_q)
            ST_HDR: begin
                is_complete    = (cnt_q == CNT_WIDTH'(HEADER_BEATS - 1)) || axis_in_tlast;
                axis_in_tready = is_complete ? hdr_slot_free : 1'b1;
                if (axis_in_tvalid && axis_in_tready && is_complete && !axis_in_tlast)
                    state_d = ST_PAY;
            end
            ST_PAY: begin
                axis_in_tready = pay_slot_free;
                if (axis_in_tvalid && axis_in_tready && axis_in_tlast)
                    state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    assign hdr_accept      = (state_q == ST_HDR) && axis_in_tvalid && axis_in_tready;
    assign complete_accept = hdr_accept && is_complete;
    assign pay_accept      = (state_q == ST_PAY) && axis_in_tvalid && axis_in_tready;

    // Accumulator with the current beat dropped into slot cnt; the completing beat is
    // never stored, the header registers take this merged view directly.
    always_comb begin
        acc_data_merged = acc_data_q;
        acc_keep_merged = acc_keep_q;
        for (int k = 0; k < HEADER_BEATS; k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
                acc_data_merged[k*TDATA_WIDTH +: TDATA_WIDTH] = axis_in_tdata;
                acc_keep_merged[k*TKEEP_WIDTH +: TKEEP_WIDTH] = axis_in_tkeep;
            end
        end
    end

    assign first_user = (cnt_q == '0) ? axis_in_tuser : pkt_user_q;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q    <= ST_HDR;
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            pkt_user_q <= '0;
        end else begin
            state_q <= state_d;
            if (hdr_accept) begin
                pkt_user_q <= first_user;
                if (is_complete) begin
                    cnt_q      <= '0;
                    acc_data_q <= '0;
                    acc_keep_q <= '0;
                end else begin
                    cnt_q      <= cnt_q + CNT_WIDTH'(1);
                    acc_data_q <= acc_data_merged;
                    acc_keep_q <= acc_keep_merged;
                end
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            header_tvalid <= 1'b0;
            header_tdata  <= '0;
            header_tkeep  <= '0;
            header_tuser  <= '0;
            header_beats  <= '0;
            header_short  <= 1'b0;
        end else if (complete_accept) begin
            header_tvalid <= 1'b1;
            header_tdata  <= acc_data_merged;
            header_tkeep  <= acc_keep_merged;
            header_tuser  <= first_user;
            header_beats  <= cnt_q + CNT_WIDTH'(1);
            header_short  <= axis_in_tlast && (cnt_q < CNT_WIDTH'(HEADER_BEATS - 1));
        end else if (header_tready) begin
            header_tvalid <= 1'b0;
            header_tdata  <= '0;
            header_tkeep  <= '0;
            header_tuser  <= '0;
            header_beats  <= '0;
            header_short  <= 1'b0;
        end
    end

    // Payload register drains on its own so header collection of the next packet can overlap.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            axis_payload_tvalid <= 1'b0;
            axis_payload_tdata  <= '0;
            axis_payload_tkeep  <= '0;
            axis_payload_tuser  <= '0;
            axis_payload_tlast  <= 1'b0;
        end else if (pay_accept) begin
            axis_payload_tvalid <= 1'b1;
            axis_payload_tdata  <= axis_in_tdata;
            axis_payload_tkeep  <= axis_in_tkeep;
            axis_payload_tuser  <= pkt_user_q;
            axis_payload_tlast  <= axis_in_tlast;
        end else if (axis_payload_tready) begin
            axis_payload_tvalid <= 1'b0;
        end
    end

endmodule

// File: doc/axis_header_splitter.md
Name: axis_header_splitter

Overview:
- Downstream neighbour of the AXIS data width converter. Consumes its narrow AXI4-Stream output.
- Collects the first HEADER_BEATS beats of each packet into one wide header word and presents it on a separate valid/ready header channel for parser/lookup logic.
- Forwards all remaining beats of the packet on a registered payload AXIS output.

Parameters:
- TDATA_WIDTH, 64, input/payload data width in bits; multiple of 8.
- TUSER_WIDTH, 128, sideband width; captured from the first beat of each packet.
- HEADER_BEATS, 4, number of leading beats gathered into the header; must be ≥1.
- Derived: TKEEP_WIDTH = TDATA_WIDTH/8; HDR_WIDTH = HEADER_BEATS*TDATA_WIDTH; CNT_WIDTH = clog2(HEADER_BEATS+1).

Ports:
- axis_aclk  in  1  clock; all logic on its rising edge.
- axis_resetn  in  1  asynchronous active-low reset.
- axis_in_tdata  in  TDATA_WIDTH  input beat data.
- axis_in_tkeep  in  TKEEP_WIDTH  input byte enables.
- axis_in_tuser  in  TUSER_WIDTH  input sideband.
- axis_in_tvalid  in  1  input beat valid.
- axis_in_tready  out  1  input beat accepted when high with tvalid.
- axis_in_tlast  in  1  last beat of packet.
- header_tdata  out  HDR_WIDTH  gathered header; beat k at bits [k*TDATA_WIDTH +: TDATA_WIDTH].
- header_tkeep  out  HEADER_BEATS*TKEEP_WIDTH  gathered byte enables, same packing.
- header_tuser  out  TUSER_WIDTH  tuser of first packet beat.
- header_beats  out  CNT_WIDTH  beats actually captured (1..HEADER_BEATS).
- header_short  out  1  packet ended before HEADER_BEATS beats.
- header_tvalid  out  1  header word valid.
- header_tready  in  1  consumer accepts header.
- axis_payload_tdata  out  TDATA_WIDTH  payload beat data.
- axis_payload_tkeep  out  TKEEP_WIDTH  payload byte enables.
- axis_payload_tuser  out  TUSER_WIDTH  tuser of first packet beat, held for all payload beats.
- axis_payload_tvalid  out  1  payload beat valid.
- axis_payload_tready  in  1  payload consumer ready.
- axis_payload_tlast  out  1  last payload beat.

Behaviour:
- Reset: async on axis_resetn low.
  - All tvalid outputs 0; header_short 0; header_beats 0.
  - All data/keep/user registers 0; state HDR; beat counter 0.
- Reset mid-packet abandons the packet. The first beat after reset is treated as a packet start.
- State HDR (collecting):
  - Each accepted beat is written into accumulator slot cnt, then cnt increments.
  - Slots not written in the current packet read as 0 (tdata and tkeep).
  - The beat with cnt==0 also latches tuser.
- Completion beat: the HDR beat with cnt==HEADER_BEATS-1 or with tlast=1.
  - Accepted only if the output header slot is free: !header_tvalid || header_tready.
  - Otherwise axis_in_tready=0 for that beat. Non-completion HDR beats are always accepted (tready=1).
- On completion handshake:
  - Accumulator is copied to the header output registers.
  - header_beats = cnt+1.
  - header_short = tlast && (cnt+1 < HEADER_BEATS).
  - header_tvalid=1 on the next cycle, so latency is 1 cycle after the completing beat.
  - cnt resets to 0 and the accumulator clears.
  - Next state is PAY if tlast=0, else HDR.
- Header output is held stable while header_tvalid && !header_tready.
  - Cleared after the handshake unless reloaded in the same cycle; back-to-back reload is allowed.
- State PAY (forwarding):
  - axis_in_tready = !axis_payload_tvalid || axis_payload_tready.
  - Accepted beats load the payload register; axis_payload_tvalid=1 next cycle.
  - Latency 1 cycle; throughput 1 beat/cycle under continuous ready.
  - tuser output is the latched first-beat tuser.
  - An accepted beat with tlast=1 returns the state to HDR.
  - Header-channel backpressure never stalls PAY.
- A packet of exactly HEADER_BEATS beats produces a header with header_short=0 and no payload beats.
- Payload register drains independently: the next packet's header beats may be collected while a payload beat awaits tready.
- axis_in_tkeep is passed through unmodified; no compaction.
- No combinational path from any input valid to axis_in_tready, except header_tready/axis_payload_tready.

Test Plan:
- 7-beat packet, HEADER_BEATS=4, data 0x01..0x07, all readies high:
  - header_tvalid one cycle after beat 4, with slots 0..3 = 0x01..0x04, header_beats=4, header_short=0.
  - Payload 0x05,0x06,0x07 on consecutive cycles, tlast on 0x07.
- 2-beat packet (tlast on beat 2):
  - header_short=1, header_beats=2, slots 2..3 tdata/tkeep = 0.
  - No payload beat; next packet's beat accepted the cycle after.
- header_tready=0 while second 4-beat packet arrives:
  - Beats 1..3 accepted; beat 4 stalls (axis_in_tready=0) until header_tready=1.
  - First header is held unchanged throughout; second header appears the next cycle.
- axis_payload_tready toggling 1010 during a 10-beat payload: no beat lost or duplicated, order preserved, tlast only on the final beat.
- Exactly-4-beat packet followed immediately by a 6-beat packet: header 1 has no payload; packet 2 yields 2 payload beats with tuser equal to packet 2 first-beat tuser.
- axis_resetn pulsed low during PAY:
  - All valids drop asynchronously.
  - After release, a new 5-beat packet yields a correct header plus 1 payload beat.
